// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types, defaults and helpers for the bus arbiter
package bus_arb_pkg;

    // Arbiter FSM states: no owner, bus owned, one-cycle dead gap between owners
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    localparam int DEF_N_REQ    = 4;
    localparam int DEF_WIDTH    = 8;
    localparam int DEF_MAX_HOLD = 8;

    // Width of an index into n items; never below one bit so ports stay legal
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arbiter_rr_picker.sv
// rtl/bus_arbiter_rr_picker.sv - round-robin winner search starting at rr_ptr
module rr_picker
    import bus_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
) (
    input  logic [N_REQ-1:0]            req,
    input  logic [idx_width(N_REQ)-1:0] rr_ptr,
    output logic                        found,
    output logic [idx_width(N_REQ)-1:0] idx
);

    localparam int IW = idx_width(N_REQ);

    // Scan offsets from farthest to nearest so the nearest set bit at or above rr_ptr wins
    always_comb begin
        int pos;
        pos   = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos = (int'(rr_ptr) + k) % N_REQ;
            if (req[pos]) begin
                found = 1'b1;
                idx   = IW'(pos);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin shared-bus arbiter with hold timeout and pre-emption
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*WIDTH-1:0]      req_data,
    output logic [N_REQ-1:0]            grant,
    output logic [idx_width(N_REQ)-1:0] owner,
    output logic [WIDTH-1:0]            bus,
    output logic                        bus_valid,
    output logic                        preempt
);

    localparam int IW = idx_width(N_REQ);
    localparam int HW = idx_width(MAX_HOLD);

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_OWN  = OWN;
    localparam logic [1:0] ST_GAP  = GAP;

    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_REQ - 1);

    logic [1:0]    state;
    logic [IW-1:0] rr_ptr;
    logic [HW-1:0] hold_cnt;

    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic [IW-1:0] next_ptr;
    logic          owner_req;
    logic          others_req;
    logic          hold_max;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req    (req),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    assign next_ptr   = (pick_idx == IDX_LAST) ? '0 : pick_idx + 1'b1;
    assign owner_req  = req[owner];
    assign others_req = |(req & ~grant);
    assign hold_max   = (hold_cnt == HOLD_LAST);

    // Arbitration FSM: grant on entry to OWN, release or pre-empt through a single GAP cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            grant    <= '0;
            owner    <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            preempt  <= 1'b0;
        end else begin
            preempt <= 1'b0;
            case (state)
                ST_OWN: begin
                    // A dropped request wins over a coincident timeout: normal release, no pulse
                    if (!owner_req) begin
                        state <= ST_GAP;
                        grant <= '0;
                    end else if (hold_max && others_req) begin
                        state   <= ST_GAP;
                        grant   <= '0;
                        preempt <= 1'b1;
                    end else if (!hold_max) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: begin
                    // IDLE and GAP arbitrate identically; an illegal code falls in here too
                    if (pick_found) begin
                        state    <= ST_OWN;
                        grant    <= N_REQ'(1) << pick_idx;
                        owner    <= pick_idx;
                        rr_ptr   <= next_ptr;
                        hold_cnt <= '0;
                    end else begin
                        state <= ST_IDLE;
                        grant <= '0;
                    end
                end
            endcase
        end
    end

    // Shared bus follows registered grant/owner only, so reset clears it without a clock
    assign bus_valid = |grant;
    assign bus       = bus_valid ? req_data[owner*WIDTH +: WIDTH] : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - self-checking bench for bus_arbiter
module tb_bus_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MH = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic [W-1:0]   bus;
    logic           bus_valid;
    logic           preempt;

    int tests = 0;
    int fails = 0;

    // reference model: who owns the bus, how long, and where the next search starts
    int m_owner;
    int m_last;
    int m_ptr;
    int m_cycles;
    bit m_pre;

    typedef struct {
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [1:0] exp_owner;
    } vec_t;

    vec_t tbl [13];

    bus_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_HOLD(MH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .grant     (grant),
        .owner     (owner),
        .bus       (bus),
        .bus_valid (bus_valid),
        .preempt   (preempt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_owner  = -1;
        m_last   = 0;
        m_ptr    = 0;
        m_cycles = 0;
        m_pre    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] r);
        m_pre = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && r[(m_ptr + k) % N]) m_owner = (m_ptr + k) % N;
            end
            if (m_owner >= 0) begin
                m_last   = m_owner;
                m_ptr    = (m_owner + 1) % N;
                m_cycles = 1;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (m_cycles >= MH && (r & ~(N'(1) << m_owner)) != 0) begin
            m_owner = -1;
            m_pre   = 1'b1;
        end else begin
            m_cycles++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        repeat (2) tick();
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [3:0]   exp_g;
        logic [W-1:0] exp_bus;
        int           own0;
        int           pre_cnt;
        int           gaps;
        int           bad;
        bit           seen2;

        tbl[0]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[1]  = '{4'b1111, 4'b0001, 2'd0};
        tbl[2]  = '{4'b1110, 4'b0000, 2'd0};
        tbl[3]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[4]  = '{4'b1111, 4'b0010, 2'd1};
        tbl[5]  = '{4'b1101, 4'b0000, 2'd1};
        tbl[6]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[7]  = '{4'b1111, 4'b0100, 2'd2};
        tbl[8]  = '{4'b1011, 4'b0000, 2'd2};
        tbl[9]  = '{4'b1111, 4'b1000, 2'd3};
        tbl[10] = '{4'b1111, 4'b1000, 2'd3};
        tbl[11] = '{4'b0111, 4'b0000, 2'd3};
        tbl[12] = '{4'b1111, 4'b0001, 2'd0};

        // reset held with all requests up: nothing granted, bus quiet
        reset    = 1'b0;
        req      = 4'b1111;
        req_data = 32'h44332211;
        #2;
        check("reset_grant", 32'(grant), 32'h0);
        check("reset_bus", 32'(bus), 32'h0);
        check("reset_valid", 32'(bus_valid), 32'h0);
        check("reset_owner", 32'(owner), 32'h0);
        check("reset_preempt", 32'(preempt), 32'h0);
        repeat (3) tick();
        check("reset_hold_grant", 32'(grant), 32'h0);
        reset = 1'b1;
        tick();
        check("release_first_grant", 32'(grant), 32'h1);
        check("release_first_bus", 32'(bus), 32'h11);

        // rotation table: each owner drops after two OWN cycles
        do_reset();
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            tick();
            check($sformatf("rot_grant[%0d]", i), 32'(grant), 32'(tbl[i].exp_grant));
            check($sformatf("rot_owner[%0d]", i), 32'(owner), 32'(tbl[i].exp_owner));
            check($sformatf("rot_valid[%0d]", i), 32'(bus_valid), 32'(tbl[i].exp_grant != 0));
        end

        // timeout pre-emption with a competing request raised mid-ownership
        do_reset();
        req     = 4'b0001;
        own0    = 0;
        pre_cnt = 0;
        gaps    = 0;
        seen2   = 1'b0;
        for (int i = 0; i < 30 && !seen2; i++) begin
            if (i == 3) req = 4'b0101;
            tick();
            if (preempt) pre_cnt++;
            if (grant == 4'b0001) own0++;
            else if (grant == 4'b0000 && own0 > 0) begin
                gaps++;
                check("preempt_in_gap", 32'(preempt), 32'h1);
            end else if (grant == 4'b0100) seen2 = 1'b1;
        end
        check("preempt_own_cycles", 32'(own0), 32'd8);
        check("preempt_pulses", 32'(pre_cnt), 32'd1);
        check("preempt_gap_cycles", 32'(gaps), 32'd1);
        check("preempt_next_owner", 32'(seen2), 32'd1);

        // a lone requester keeps the bus indefinitely
        do_reset();
        req = 4'b0010;
        bad = 0;
        pre_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (grant != 4'b0010) bad++;
            if (preempt) pre_cnt++;
        end
        check("sole_grant_breaks", 32'(bad), 32'd0);
        check("sole_preempts", 32'(pre_cnt), 32'd0);

        // bus mux follows the owner lane, zero in the gap
        do_reset();
        req_data = 32'h00A50000;
        req      = 4'b0100;
        tick();
        check("bus_lane2", 32'(bus), 32'hA5);
        check("bus_lane2_valid", 32'(bus_valid), 32'h1);
        check("bus_lane2_owner", 32'(owner), 32'd2);
        req = 4'b0000;
        tick();
        check("bus_gap", 32'(bus), 32'h0);
        check("bus_gap_valid", 32'(bus_valid), 32'h0);
        check("bus_gap_owner", 32'(owner), 32'd2);

        // asynchronous reset while owning, then arbitration restarts at lane 0
        do_reset();
        req_data = 32'h44332211;
        req      = 4'b1111;
        tick();
        tick();
        check("async_pre_grant", 32'(grant), 32'h1);
        #3;
        reset = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'h0);
        check("async_bus", 32'(bus), 32'h0);
        check("async_valid", 32'(bus_valid), 32'h0);
        #1;
        reset = 1'b1;
        tick();
        check("async_restart_grant", 32'(grant), 32'h1);

        // timeout and release in the same cycle count as a plain release
        do_reset();
        req = 4'b0011;
        repeat (MH) tick();
        check("coinc_still_owner", 32'(grant), 32'h1);
        req = 4'b0010;
        tick();
        check("coinc_gap_grant", 32'(grant), 32'h0);
        check("coinc_preempt", 32'(preempt), 32'h0);
        tick();
        check("coinc_next_grant", 32'(grant), 32'h2);

        // randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 9) == 0) req[b] = ~req[b];
            end
            req_data = $urandom;
            tick();
            model_step(req);
            exp_g   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            exp_bus = (m_owner >= 0) ? req_data[m_owner*W +: W] : '0;
            check($sformatf("rnd_grant[%0d]", i), 32'(grant), 32'(exp_g));
            check($sformatf("rnd_owner[%0d]", i), 32'(owner), 32'(m_last));
            check($sformatf("rnd_bus[%0d]", i), 32'(bus), 32'(exp_bus));
            check($sformatf("rnd_preempt[%0d]", i), 32'(preempt), 32'(m_pre));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 Parameters SHALL be:
  - N_REQ, default 4, number of bus requesters.
  - WIDTH, default 8, bus width.
  - MAX_HOLD, default 8, maximum cycles one owner keeps the bus while others wait.
REQ-002 Ports SHALL be:
  - clk  input  1  single clock, rising edge.
  - reset  input  1  asynchronous, active-low.
  - req  input  N_REQ  level request per requester; held high while owning.
  - req_data  input  N_REQ*WIDTH  drive data, lane i at bits [i*WIDTH +: WIDTH].
  - grant  output  N_REQ  one-hot or zero, registered.
  - owner  output  clog2(N_REQ)  index of current/last owner, registered.
  - bus  output  WIDTH  muxed shared-bus value.
  - bus_valid  output  1  high when grant is nonzero.
  - preempt  output  1  one-cycle pulse when the owner is forcibly released.

Function
REQ-003 The FSM SHALL have states IDLE (no owner), OWN (grant = onehot(owner)) and GAP (all grants 0 for exactly one cycle).
REQ-004 In IDLE or GAP with any req high, the block SHALL select a winner and enter OWN; grant is visible after that edge (1-cycle latency from req).
REQ-005 IDLE or GAP with req = 0 SHALL go to IDLE.
REQ-006 Winner selection SHALL be round-robin: the first set req bit searching upward from rr_ptr, wrapping at N_REQ-1 -> 0.
REQ-007 On entering OWN, rr_ptr SHALL become (winner+1) mod N_REQ.
REQ-008 hold_cnt SHALL clear on entry to OWN, increment each OWN cycle, and saturate at MAX_HOLD-1.
REQ-009 In OWN, req[owner] low SHALL cause transition to GAP (normal release), with preempt = 0.
REQ-010 In OWN, hold_cnt = MAX_HOLD-1 with req[owner] still high and any other req high SHALL cause transition to GAP with a preempt pulse in that same transition cycle.
REQ-011 If release and timeout coincide in one cycle, the event SHALL be a normal release with no preempt.
REQ-012 A sole requester SHALL never be preempted; grant stays continuous and hold_cnt stays saturated.
REQ-013 A preempted requester whose req is still high SHALL be treated as a fresh request and ranked behind others by rr_ptr.
REQ-014 A lane whose req rises during OWN SHALL wait; no grant changes except through GAP.
REQ-015 bus SHALL equal req_data lane [owner] when grant is nonzero, else all zeros. This path is combinational from the registered grant/owner only.
REQ-016 bus_valid SHALL equal |grant; grant SHALL never have more than one bit set.

Reset
REQ-017 reset low SHALL immediately, without a clock edge, force:
  - state = IDLE
  - grant = 0, bus_valid = 0, bus = 0
  - owner = 0, rr_ptr = 0, hold_cnt = 0, preempt = 0
REQ-018 Reset mid-OWN SHALL drop grant asynchronously. After reset deasserts, arbitration restarts from rr_ptr = 0.

Structure
REQ-019 A shared package bus_arb_pkg SHALL hold:
  - the state enum (IDLE, OWN, GAP)
  - default N_REQ, WIDTH and MAX_HOLD constants
  - an index-width function
REQ-020 One combinational sub-module rr_picker (inputs req and rr_ptr; outputs found and idx) SHALL implement REQ-006.
REQ-021 FSM, counters and bus mux SHALL reside in bus_arbiter.

Verification
REQ-022 Hold reset=0 with req=4'b1111 -> grant=0, bus=8'h00, bus_valid=0. Release reset -> grant=4'b0001 after the first edge.
REQ-023 req=4'b1111, each owner drops req after 2 OWN cycles -> grant sequence 0001, 0010, 0100, 1000, 0001, with one all-zero GAP cycle between each.
REQ-024 MAX_HOLD=8, req[0] held high, req[2] raised 3 cycles into OWN:
  - grant = 0001 for exactly 8 cycles
  - preempt pulses once
  - one GAP cycle
  - then grant = 0100
REQ-025 req[1] alone held for 20 cycles -> grant = 0010 continuous, preempt never asserted.
REQ-026 req_data lane 2 = 8'hA5, owner 2 -> bus = 8'hA5, bus_valid = 1. In the following GAP -> bus = 8'h00, bus_valid = 0.
REQ-027 Drive reset low between clock edges during OWN -> grant = 0 before the next edge. Also check that a timeout in the same cycle as req[owner] falling gives preempt = 0.
